// File: rtl/sobel_x_col_sequencer_if.sv
// Column-stream and result-stream bundle for the Sobel-X column sequencer.
//
// Purpose: groups the two valid/ready channels of the sequencer so that a
// producer/consumer (master) and the sequencer (slave) share one connection.
//
// Signals:
//   in_valid / in_ready   column input handshake (master -> slave)
//   in_col                SIZE pixels of 8 bits, pixel i at bits [8i+7:8i]
//   out_valid / out_ready result handshake (slave -> master)
//   out_data              (SIZE-2) results of 10 bits each
//   out_col_idx           window-centre column index of out_data
//   out_last              out_data is the final result of the frame
interface sobel_x_col_sequencer_if #(
    parameter int SIZE = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [SIZE*8-1:0]        in_col;
    logic                     out_valid;
    logic                     out_ready;
    logic [(SIZE-2)*10-1:0]   out_data;
    logic [11:0]              out_col_idx;
    logic                     out_last;

    modport master (
        output in_valid, in_col, out_ready,
        input  in_ready, out_valid, out_data, out_col_idx, out_last
    );

    modport slave (
        input  in_valid, in_col, out_ready,
        output in_ready, out_valid, out_data, out_col_idx, out_last
    );
endinterface

// File: rtl/sobel_x_col_sequencer.sv
// Sobel-X column sequencer.
//
// Purpose: accepts a frame of pixel columns, feeds them one at a time to an
// external Sobel-X datapath, tracks which datapath results belong to a full
// 3-column window, and buffers those results (with their centre-column index
// and a last-of-frame flag) in a small show-ahead FIFO. Input acceptance is
// throttled so that every result already promised to the FIFO has a slot.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle frame start pulse (honoured only when idle)
//   width_cfg    frame width in columns, sampled on an accepted start
//   bus          slave side of the column/result streams
//   dp_en        one-cycle strobe: datapath shifts in dp_col
//   dp_col       registered column presented to the datapath
//   dp_res       datapath result, valid DP_LAT cycles after dp_en
//   busy         frame in progress (RUN or DRAIN)
//   done         one-cycle pulse when the frame has fully drained
module sobel_x_col_sequencer #(
    parameter int SIZE       = 3,
    parameter int DP_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [11:0]            width_cfg,
    sobel_x_col_sequencer_if.slave bus,
    output logic                   dp_en,
    output logic [SIZE*8-1:0]      dp_col,
    input  logic [(SIZE-2)*10-1:0] dp_res,
    output logic                   busy,
    output logic                   done
);
    localparam int RW = (SIZE-2)*10;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, state_next;
    logic [11:0] width_reg;
    logic [11:0] col_cnt;
    logic [AW:0] inflight;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] fifo_count;
    logic        fifo_empty;
    logic        accept;
    logic        tag_new;
    logic        wr_en;
    logic        rd_en;

    // Delay line: stage 0 lines up with dp_en, stage DP_LAT with dp_res.
    logic [DP_LAT:0] tag_pipe;
    logic [11:0]     idx_pipe  [DP_LAT+1];
    logic            last_pipe [DP_LAT+1];

    logic [RW-1:0] mem_data [FIFO_DEPTH];
    logic [11:0]   mem_idx  [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Reserve a FIFO slot for every tagged column still inside the datapath,
    // so a write can never find the FIFO full.
    assign bus.in_ready = (state == RUN) &&
        (({1'b0, fifo_count} + {1'b0, inflight}) < (AW+2)'(FIFO_DEPTH));
    assign accept  = bus.in_valid && bus.in_ready;
    // The first two columns only fill the window; they produce no result.
    assign tag_new = accept && (col_cnt >= 12'd2);
    assign wr_en   = tag_pipe[DP_LAT];
    assign rd_en   = !fifo_empty && bus.out_ready;
    assign busy    = (state != IDLE);

    // Show-ahead head; outputs are gated so they read as zero while empty.
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = fifo_empty ? '0    : mem_data[rd_ptr[AW-1:0]];
    assign bus.out_col_idx = fifo_empty ? '0    : mem_idx[rd_ptr[AW-1:0]];
    assign bus.out_last    = fifo_empty ? 1'b0  : mem_last[rd_ptr[AW-1:0]];

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (accept && (col_cnt == width_reg - 12'd1)) state_next = DRAIN;
            DRAIN: if ((inflight == '0) && fifo_empty && (tag_pipe == '0)) begin
                       state_next = IDLE;
                       done       = 1'b1;
                   end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            width_reg <= 12'd3;
            col_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                width_reg <= (width_cfg < 12'd3) ? 12'd3 : width_cfg;
                col_cnt   <= '0;
            end else if (accept) begin
                col_cnt <= col_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_en  <= 1'b0;
            dp_col <= '0;
        end else begin
            dp_en <= accept;
            if (accept) dp_col <= bus.in_col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe <= '0;
            for (int i = 0; i <= DP_LAT; i++) begin
                idx_pipe[i]  <= '0;
                last_pipe[i] <= 1'b0;
            end
        end else begin
            tag_pipe     <= {tag_pipe[DP_LAT-1:0], tag_new};
            // The result of column c is centred on column c-1.
            idx_pipe[0]  <= col_cnt - 12'd1;
            last_pipe[0] <= (col_cnt == width_reg - 12'd1);
            for (int i = 1; i <= DP_LAT; i++) begin
                idx_pipe[i]  <= idx_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({tag_new, wr_en})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr[AW-1:0]] <= dp_res;
            mem_idx[wr_ptr[AW-1:0]]  <= idx_pipe[DP_LAT];
            mem_last[wr_ptr[AW-1:0]] <= last_pipe[DP_LAT];
        end
    end
endmodule

// File: tb/tb_sobel_x_col_sequencer.sv
// Testbench for sobel_x_col_sequencer (SIZE = 3, DP_LAT = 1, FIFO_DEPTH = 4).
// A behavioural Sobel-X datapath closes the loop; expected results are queued
// when columns are issued and a monitor pops and compares every output beat.
module tb_sobel_x_col_sequencer;
    localparam int SIZE = 3;

    typedef struct packed {
        logic [9:0]  data;
        logic [11:0] idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] width_cfg = '0;
    logic        dp_en;
    logic [23:0] dp_col;
    logic [9:0]  dp_res = '0;
    logic        busy;
    logic        done;

    logic [23:0] h0 = '0, h1 = '0;
    logic [23:0] colhist [0:15];
    exp_t        sb [$];
    exp_t        mon_e;
    int          total = 0, bad = 0, n_out = 0, done_cnt = 0, stalls = 0;

    sobel_x_col_sequencer_if #(.SIZE(SIZE)) bus ();

    sobel_x_col_sequencer #(.SIZE(SIZE), .DP_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .width_cfg(width_cfg),
        .bus(bus), .dp_en(dp_en), .dp_col(dp_col), .dp_res(dp_res),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] sobel(input logic [23:0] o, input logic [23:0] n);
        int so, sn, g;
        so = int'(o[7:0]) + 2*int'(o[15:8]) + int'(o[23:16]);
        sn = int'(n[7:0]) + 2*int'(n[15:8]) + int'(n[23:16]);
        g  = sn - so;
        if (g < 0) g = -g;
        return 10'(g);
    endfunction

    function automatic logic [23:0] gen(input int k, input int s);
        return {8'((k*53 + s*7 + 200) % 256), 8'((k*29 + s) % 256), 8'((k*71 + s*3 + 17) % 256)};
    endfunction

    // Datapath model: latency 1, window = two previous columns plus the new one.
    always @(posedge clk) begin
        if (dp_en) begin
            h1     <= h0;
            h0     <= dp_col;
            dp_res <= sobel(h1, dp_col);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got idx=%0d data=%0d expected no output",
                             bus.out_col_idx, bus.out_data);
                end else begin
                    mon_e = sb.pop_front();
                    $display("out idx=%0d data=%0d last=%0d", bus.out_col_idx, bus.out_data, bus.out_last);
                    chk("out_data", int'(bus.out_data), int'(mon_e.data));
                    chk("out_col_idx", int'(bus.out_col_idx), int'(mon_e.idx));
                    chk("out_last", int'(bus.out_last), int'(mon_e.last));
                    n_out++;
                end
            end
        end
    end

    task automatic pulse_start(input logic [11:0] cfg);
        @(posedge clk); #1;
        start = 1'b1; width_cfg = cfg;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_frame(input logic [11:0] cfg);
        n_out = 0; done_cnt = 0;
        pulse_start(cfg);
    endtask

    task automatic send_col(input logic [23:0] c);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_col   = c;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard > 0) stalls++;
        if (guard >= 200) chk("in_ready_timeout", guard, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("dp_en_after_accept", int'(dp_en), 1);
        chk("dp_col_after_accept", int'(dp_col), int'(c));
    endtask

    task automatic feed(input int w, input int k0, input int k1, input int s);
        for (int k = k0; k <= k1; k++) begin
            colhist[k] = gen(k, s);
            if (k >= 2) sb.push_back('{data: sobel(colhist[k-2], colhist[k]), idx: 12'(k-1), last: (k == w-1)});
            send_col(colhist[k]);
        end
    endtask

    task automatic wait_frame(input int exp_n);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) chk("frame_timeout", g, 0);
        repeat (3) @(negedge clk);
        chk("result_count", n_out, exp_n);
        chk("done_count", done_cnt, 1);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_dp_en"}, int'(dp_en), 0);
        chk({tag, "_dp_col"}, int'(dp_col), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_last"}, int'(bus.out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_col    = '0;
        bus.out_ready = 1'b1;
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", int'(bus.in_ready), 0);

        // Scenario 1: W = 3, hand-computed |(60+164+71)-(88+254+165)| = 212.
        start_frame(12'd3);
        sb.push_back('{data: 10'd212, idx: 12'd1, last: 1'b1});
        send_col({8'd165, 8'd127, 8'd88});
        send_col({8'd216, 8'd174, 8'd121});
        send_col({8'd71, 8'd82, 8'd60});
        wait_frame(1);

        // Scenario 2: W = 8, continuous stream, no backpressure expected.
        start_frame(12'd8);
        stalls = 0;
        feed(8, 0, 7, 2);
        chk("s2_stalls", stalls, 0);
        wait_frame(6);

        // Scenario 3: W = 10 with the consumer stalled.
        bus.out_ready = 1'b0;
        start_frame(12'd10);
        stalls = 0;
        feed(10, 0, 5, 3);
        chk("s3_stalls_before_full", stalls, 0);
        @(negedge clk);
        chk("s3_in_ready_low", int'(bus.in_ready), 0);
        repeat (3) @(negedge clk);
        chk("s3_hold_valid", int'(bus.out_valid), 1);
        chk("s3_hold_data", int'(bus.out_data), int'(sb[0].data));
        chk("s3_hold_idx", int'(bus.out_col_idx), 1);
        chk("s3_in_ready_still_low", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        feed(10, 6, 9, 3);
        wait_frame(8);

        // Scenario 4: width below the minimum is promoted to 3.
        start_frame(12'd1);
        feed(3, 0, 2, 4);
        wait_frame(1);

        // Scenario 5: reset in the middle of a W = 8 frame.
        start_frame(12'd8);
        feed(8, 0, 4, 5);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("s5_no_output", int'(bus.out_valid), 0);
        chk("s5_idle", int'(busy), 0);
        start_frame(12'd4);
        feed(4, 0, 3, 6);
        wait_frame(2);

        // Scenario 6: a start during RUN must not change the width.
        start_frame(12'd5);
        feed(5, 0, 1, 7);
        pulse_start(12'd9);
        feed(5, 2, 4, 7);
        wait_frame(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
